// File: rtl/bp_me_timer_csr_bank.sv
// Machine timer CSR bank (mtimecmp, mtime, msip) behind a sync 1rw register port.
// Optional BP_ME_TIMER_CSR_FREEZE_EN adds freeze_i to halt the prescaler and mtime.
module bp_me_timer_csr_bank #(
    parameter int reg_width_p      = 64,
    parameter int reg_addr_width_p = 20,
    parameter int prescale_p       = 8,
    localparam int lg_reg_width_lp = $clog2($clog2(reg_width_p/8) + 1)
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [2:0]                          r_v_i,
    input  logic [2:0]                          w_v_i,
    input  logic [reg_addr_width_p-1:0]         addr_i,
    input  logic [lg_reg_width_lp-1:0]          size_i,
    input  logic [reg_width_p-1:0]              data_i,
    output logic [2:0][reg_width_p-1:0]         data_o,
    output logic                                timer_irq_o,
    output logic                                software_irq_o
`ifdef BP_ME_TIMER_CSR_FREEZE_EN
    ,input logic                                freeze_i
`endif
);

    localparam int nbytes_lp = reg_width_p / 8;
    localparam int cnt_w_lp  = (prescale_p > 1) ? $clog2(prescale_p) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(prescale_p - 1);

    if (reg_width_p != 64) begin : g_bad_width
        $error("bp_me_timer_csr_bank: only reg_width_p == 64 is supported");
    end
    if (prescale_p < 1) begin : g_bad_prescale
        $error("bp_me_timer_csr_bank: prescale_p must be >= 1");
    end

    logic [cnt_w_lp-1:0]          cnt_q, cnt_d;
    logic [reg_width_p-1:0]       mtime_q, mtime_d, mtime_inc;
    logic [reg_width_p-1:0]       mtimecmp_q, mtimecmp_d;
    logic                         msip_q, msip_d;
    logic                         timer_irq_q, timer_irq_d;
    logic [2:0][reg_width_p-1:0]  data_q, rd_val;

    logic [2:0]                   off;
    logic [3:0]                   access_bytes;
    logic                         aligned;
    logic [reg_width_p-1:0]       wmask, wdata;
    logic                         run, tick;
    logic                         unused_addr;

    assign off         = addr_i[2:0];
    assign unused_addr = ^addr_i[reg_addr_width_p-1:3];

`ifdef BP_ME_TIMER_CSR_FREEZE_EN
    assign run = ~freeze_i;
`else
    assign run = 1'b1;
`endif

    assign tick = run && (cnt_q == cnt_max_lp);

    // Byte-lane mask is zeroed for misaligned accesses so those writes drop.
    always_comb begin
        access_bytes = 4'd1 << size_i;
        aligned      = ((4'(off) & (access_bytes - 4'd1)) == 4'd0);
        wmask        = '0;
        for (int b = 0; b < nbytes_lp; b++) begin
            wmask[8*b +: 8] = {8{aligned && (b >= int'(off))
                                 && (b < int'(off) + int'(access_bytes))}};
        end
        wdata = data_i << {off, 3'b000};
    end

    always_comb begin
        cnt_d = cnt_q;
        if (run) begin
            cnt_d = tick ? '0 : cnt_q + cnt_w_lp'(1);
        end

        mtime_inc = tick ? mtime_q + reg_width_p'(1) : mtime_q;
        mtime_d   = w_v_i[1] ? ((mtime_inc & ~wmask) | (wdata & wmask)) : mtime_inc;

        mtimecmp_d = w_v_i[0] ? ((mtimecmp_q & ~wmask) | (wdata & wmask)) : mtimecmp_q;

        msip_d = (w_v_i[2] && wmask[0]) ? wdata[0] : msip_q;

        timer_irq_d = (mtime_d >= mtimecmp_d);

        rd_val[0] = mtimecmp_q;
        rd_val[1] = mtime_q;
        rd_val[2] = {{(reg_width_p-1){1'b0}}, msip_q};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            timer_irq_q <= 1'b0;
            data_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            timer_irq_q <= timer_irq_d;
            for (int i = 0; i < 3; i++) begin
                if (r_v_i[i]) begin
                    data_q[i] <= rd_val[i];
                end
            end
        end
    end

    assign data_o         = data_q;
    assign timer_irq_o    = timer_irq_q;
    assign software_irq_o = msip_q;

endmodule

// File: tb/tb_bp_me_timer_csr_bank.sv
// Bench for bp_me_timer_csr_bank: fixed vector table, directed corner sequences,
// and randomized traffic against a byte-level reference model.
module tb_bp_me_timer_csr_bank;

    localparam int P = 8;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [2:0]       r_v, w_v;
    logic [19:0]      addr;
    logic [1:0]       size;
    logic [63:0]      data;
    logic [2:0][63:0] data_o;
    logic             timer_irq_o, software_irq_o;
    logic             freeze = 1'b0;

    int checks = 0;
    int errors = 0;

    bp_me_timer_csr_bank #(
        .reg_width_p(64), .reg_addr_width_p(20), .prescale_p(P)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .r_v_i(r_v), .w_v_i(w_v),
        .addr_i(addr), .size_i(size), .data_i(data), .data_o(data_o),
        .timer_irq_o(timer_irq_o), .software_irq_o(software_irq_o)
`ifdef BP_ME_TIMER_CSR_FREEZE_EN
        , .freeze_i(freeze)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: registers as plain 64-bit values, timing as a count of
    // unfrozen edges since reset.
    logic [63:0] m_time, m_cmp;
    logic [63:0] m_data [3];
    logic        m_sip, m_tirq;
    int unsigned m_run;

    task automatic model_reset();
        m_time = '0; m_cmp = '1; m_sip = 1'b0; m_tirq = 1'b0; m_run = 0;
        for (int i = 0; i < 3; i++) m_data[i] = '0;
    endtask

    task automatic model_edge(input logic [2:0] r, input logic [2:0] w, input logic [2:0] o,
                              input logic [1:0] sz, input logic [63:0] d, input logic frz);
        int nb;
        int idx;
        nb = 1 << sz;
        if (r[0]) m_data[0] = m_cmp;
        if (r[1]) m_data[1] = m_time;
        if (r[2]) m_data[2] = {63'b0, m_sip};
        if (!frz) begin
            if ((m_run % P) == P - 1) m_time = m_time + 64'd1;
            m_run++;
        end
        if ((int'(o) % nb) == 0) begin
            for (int k = 0; k < nb; k++) begin
                idx = int'(o) + k;
                if (w[0]) m_cmp[8*idx +: 8]  = d[8*k +: 8];
                if (w[1]) m_time[8*idx +: 8] = d[8*k +: 8];
                if (w[2] && idx == 0) m_sip = d[0];
            end
        end
        m_tirq = (m_time >= m_cmp);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] r, input logic [2:0] w, input logic [2:0] o,
                        input logic [1:0] sz, input logic [63:0] d);
        r_v = r; w_v = w; addr = {17'($urandom), o}; size = sz; data = d;
        @(posedge clk);
        model_edge(r, w, o, sz, d, freeze);
        #1;
        chk("model_timer_irq", {63'b0, timer_irq_o}, {63'b0, m_tirq});
        chk("model_software_irq", {63'b0, software_irq_o}, {63'b0, m_sip});
        for (int i = 0; i < 3; i++) chk($sformatf("model_data_o[%0d]", i), data_o[i], m_data[i]);
        r_v = '0; w_v = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 3'b000, 3'd0, 2'd0, 64'd0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1; r_v = '0; w_v = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_data_o", data_o[0] | data_o[1] | data_o[2], 64'd0);
        chk("reset_timer_irq", {63'b0, timer_irq_o}, 64'd0);
        chk("reset_software_irq", {63'b0, software_irq_o}, 64'd0);
        reset_i = 1'b0;
    endtask

    function automatic int rd_idx(input logic [2:0] r);
        return r[0] ? 0 : (r[1] ? 1 : 2);
    endfunction

    typedef struct {
        logic [2:0]  r;
        logic [2:0]  w;
        logic [2:0]  o;
        logic [1:0]  sz;
        logic [63:0] d;
        logic [63:0] exp_rd;
        logic        exp_ti;
        logic        exp_sw;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int rise;
        int op, ri;
        logic [63:0] rd;

        // One entry per cycle starting right after reset; ticks fall on cycles 8, 16.
        tbl[0]  = '{3'b000, 3'b010, 3'd0, 2'd3, 64'h10,               64'h0,                 1'b0, 1'b0};
        tbl[1]  = '{3'b000, 3'b010, 3'd4, 2'd2, 64'hDEAD,             64'h0,                 1'b0, 1'b0};
        tbl[2]  = '{3'b010, 3'b000, 3'd0, 2'd3, 64'h0,                64'h0000DEAD00000010,  1'b0, 1'b0};
        tbl[3]  = '{3'b000, 3'b010, 3'd2, 2'd2, 64'hBEEF,             64'h0,                 1'b0, 1'b0};
        tbl[4]  = '{3'b010, 3'b000, 3'd2, 2'd2, 64'h0,                64'h0000DEAD00000010,  1'b0, 1'b0};
        tbl[5]  = '{3'b000, 3'b001, 3'd0, 2'd3, 64'h0000DEAD00000011, 64'h0,                 1'b0, 1'b0};
        tbl[6]  = '{3'b000, 3'b000, 3'd0, 2'd0, 64'h0,                64'h0,                 1'b0, 1'b0};
        tbl[7]  = '{3'b000, 3'b000, 3'd0, 2'd0, 64'h0,                64'h0,                 1'b1, 1'b0};
        tbl[8]  = '{3'b000, 3'b100, 3'd0, 2'd0, 64'hFF,               64'h0,                 1'b1, 1'b1};
        tbl[9]  = '{3'b100, 3'b000, 3'd0, 2'd3, 64'h0,                64'h1,                 1'b1, 1'b1};
        tbl[10] = '{3'b000, 3'b001, 3'd6, 2'd1, 64'hFFFF,             64'h0,                 1'b0, 1'b1};
        tbl[11] = '{3'b001, 3'b000, 3'd0, 2'd3, 64'h0,                64'hFFFFDEAD00000011,  1'b0, 1'b1};
        tbl[12] = '{3'b000, 3'b100, 3'd0, 2'd3, 64'h0,                64'h0,                 1'b0, 1'b0};
        tbl[13] = '{3'b100, 3'b000, 3'd0, 2'd3, 64'h0,                64'h0,                 1'b0, 1'b0};
        tbl[14] = '{3'b000, 3'b010, 3'd0, 2'd0, 64'hAA,               64'h0,                 1'b0, 1'b0};
        tbl[15] = '{3'b000, 3'b010, 3'd1, 2'd0, 64'h55,               64'h0,                 1'b0, 1'b0};
        tbl[16] = '{3'b010, 3'b000, 3'd0, 2'd3, 64'h0,                64'h0000DEAD000055AB,  1'b0, 1'b0};
        tbl[17] = '{3'b000, 3'b001, 3'd4, 2'd3, 64'h0,                64'h0,                 1'b0, 1'b0};
        tbl[18] = '{3'b001, 3'b000, 3'd4, 2'd3, 64'h0,                64'hFFFFDEAD00000011,  1'b0, 1'b0};

        reset_i = 1'b1; r_v = '0; w_v = '0; addr = '0; size = '0; data = '0;
        #12;
        do_reset();

        for (int v = 0; v < 19; v++) begin
            step(tbl[v].r, tbl[v].w, tbl[v].o, tbl[v].sz, tbl[v].d);
            if (tbl[v].r != 3'b000)
                chk($sformatf("vec%0d_read", v), data_o[rd_idx(tbl[v].r)], tbl[v].exp_rd);
            chk($sformatf("vec%0d_timer_irq", v), {63'b0, timer_irq_o}, {63'b0, tbl[v].exp_ti});
            chk($sformatf("vec%0d_software_irq", v), {63'b0, software_irq_o}, {63'b0, tbl[v].exp_sw});
        end

        // Asynchronous reset in the middle of a prescale period.
        do_reset();
        step(3'b000, 3'b010, 3'd0, 2'd3, 64'h55);
        step(3'b000, 3'b001, 3'd0, 2'd3, 64'h0);
        step(3'b010, 3'b000, 3'd0, 2'd3, 64'h0);
        chk("midreset_pre_read", data_o[1], 64'h55);
        #3;
        reset_i = 1'b1;
        #1;
        model_reset();
        chk("midreset_async_data_o", data_o[0] | data_o[1] | data_o[2], 64'd0);
        chk("midreset_async_timer_irq", {63'b0, timer_irq_o}, 64'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        step(3'b001, 3'b000, 3'd0, 2'd3, 64'h0);
        chk("midreset_mtimecmp", data_o[0], 64'hFFFF_FFFF_FFFF_FFFF);
        step(3'b010, 3'b000, 3'd0, 2'd3, 64'h0);
        chk("midreset_mtime", data_o[1], 64'h0);

        // Free-running count with no accesses.
        do_reset();
        idle(80);
        step(3'b010, 3'b000, 3'd0, 2'd3, 64'h0);
        chk("count_80_cycles", data_o[1], 64'd10);
        idle(15);
        step(3'b010, 3'b000, 3'd0, 2'd3, 64'h0);
        chk("count_96_cycles", data_o[1], 64'd12);

        // Timer interrupt rise edge and deassertion by a larger mtimecmp.
        do_reset();
        step(3'b000, 3'b001, 3'd0, 2'd3, 64'd5);
        rise = 0;
        for (int e = 2; e <= 100 && rise == 0; e++) begin
            idle(1);
            if (timer_irq_o) rise = e;
        end
        chk("irq_rise_cycle", 64'(rise), 64'd40);
        step(3'b010, 3'b000, 3'd0, 2'd3, 64'h0);
        chk("irq_mtime_at_rise", data_o[1], 64'd5);
        step(3'b000, 3'b001, 3'd0, 2'd3, 64'd100);
        chk("irq_fall_on_write", {63'b0, timer_irq_o}, 64'd0);

`ifdef BP_ME_TIMER_CSR_FREEZE_EN
        do_reset();
        idle(10);
        freeze = 1'b1;
        step(3'b010, 3'b000, 3'd0, 2'd3, 64'h0);
        chk("freeze_start", data_o[1], 64'd1);
        idle(40);
        step(3'b010, 3'b000, 3'd0, 2'd3, 64'h0);
        chk("freeze_held", data_o[1], 64'd1);
        step(3'b000, 3'b001, 3'd0, 2'd3, 64'h0);
        chk("freeze_irq_tracks", {63'b0, timer_irq_o}, 64'd1);
        freeze = 1'b0;
        idle(16);
        step(3'b010, 3'b000, 3'd0, 2'd3, 64'h0);
        chk("freeze_resumed", data_o[1], 64'd3);
`endif

        // Randomized traffic, including wrap-around values and near-mtime compares.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
`ifdef BP_ME_TIMER_CSR_FREEZE_EN
            if ($urandom_range(0, 15) == 0) freeze = ~freeze;
`endif
            op = $urandom_range(0, 6);
            ri = $urandom_range(0, 2);
            rd = {$urandom, $urandom};
            if (op >= 3 && ri == 1 && $urandom_range(0, 3) == 0)
                rd = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            if (op >= 3 && ri == 0 && $urandom_range(0, 1) == 0)
                rd = m_time + 64'($urandom_range(0, 20));
            if (op <= 1)
                step(3'b000, 3'b000, 3'd0, 2'd0, 64'h0);
            else if (op == 2)
                step(3'b001 << ri, 3'b000, 3'($urandom), 2'($urandom), 64'h0);
            else if ($urandom_range(0, 1) == 0)
                step(3'b000, 3'b001 << ri, 3'd0, 2'd3, rd);
            else
                step(3'b000, 3'b001 << ri, 3'($urandom), 2'($urandom), rd);
        end
        freeze = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
